// File: rtl/mbgd_batch_sequencer.sv
// mbgd_batch_sequencer: drives the MBGD dot-product adder stage and accumulates one mini-batch of adder results.
// Latency: 1 handshake cycle + ADD_LAT cycles per sample; out_valid BATCH*(1+ADD_LAT) cycles after the first handshake when fed back-to-back.
// Backpressure: in_ready only in WAIT_IN; the result is held in DONE until out_ready. Optional macro MBGD_SEQ_MEAN_EN presents the batch mean.
module mbgd_batch_sequencer #(
  parameter int N         = 8,
  parameter int N_BIT     = 3,
  parameter int DW1       = 8,
  parameter int DW2       = 8,
  parameter int BATCH     = 4,
  parameter int BATCH_BIT = 2,
  parameter int ADD_LAT   = 1
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  add_en,
  input  logic [DW1+DW2+N_BIT-1:0]              add_sum,
  output logic [DW1+DW2+N_BIT+BATCH_BIT-1:0]    acc_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic [BATCH_BIT-1:0]                  sample_cnt
);

  localparam int SW = DW1 + DW2 + N_BIT;
  localparam int AW = SW + BATCH_BIT;
  localparam int LW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [LW-1:0]        LAT_MAX  = LW'(ADD_LAT);
  localparam logic [BATCH_BIT-1:0] CNT_LAST = BATCH_BIT'(BATCH - 1);

  // The adder output only holds the full sum of N lanes if N fits in N_BIT bits.
  if (N > (1 << N_BIT)) begin : g_lane_chk
    $error("mbgd_batch_sequencer: N=%0d exceeds 2**N_BIT", N);
  end
  if (BATCH < 1 || ADD_LAT < 1) begin : g_param_chk
    $error("mbgd_batch_sequencer: BATCH and ADD_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [LW-1:0]          lat_cnt, lat_nxt;
  logic [AW-1:0]          acc, acc_nxt;
  logic [BATCH_BIT-1:0]   cnt_nxt;

  // State, latency counter, accumulator and sample count registers; reset aborts any batch in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      acc        <= '0;
      sample_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      acc        <= acc_nxt;
      sample_cnt <= cnt_nxt;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    acc_nxt   = acc;
    cnt_nxt   = sample_cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = WAIT_IN;
        end
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lat_nxt   = LW'(1);
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (lat_cnt < LAT_MAX) begin
          lat_nxt = lat_cnt + LW'(1);
        end else begin
          // add_sum is valid now: the adder has had ADD_LAT edges since capture.
          acc_nxt = acc + AW'(add_sum);
          if (sample_cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = sample_cnt + BATCH_BIT'(1);
            state_nxt = WAIT_IN;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The adder captures the held vector on the handshake edge only.
  assign add_en = in_valid & in_ready;
  assign busy   = (state != IDLE);

`ifdef MBGD_SEQ_MEAN_EN
  if (BATCH != (1 << BATCH_BIT)) begin : g_mean_chk
    $error("mbgd_batch_sequencer: mean output needs BATCH == 2**BATCH_BIT");
  end
  // The finished result (DONE, and held through IDLE) is the mean; mid-batch shows the running sum.
  assign acc_out = (state == DONE || state == IDLE) ? (acc >> BATCH_BIT) : acc;
`else
  assign acc_out = acc;
`endif

endmodule

// File: doc/mbgd_batch_sequencer.md
Name: mbgd_batch_sequencer

Overview:
- Controller for the MBGD dot-product adder stage: the N-lane adder that sums N products into one (DW1+DW2+N_BIT)-bit value on each enabled clock.
- Accepts one dot-product vector per sample through a valid/ready handshake and pulses the adder enable.
- Waits the adder latency, then accumulates the adder result over a mini-batch of BATCH samples.
- Presents the batch gradient sum downstream with a valid/ready handshake; sits between the multiplier array and the weight-update stage.

Parameters:
- N, 8, dot-product lanes feeding the adder.
- N_BIT, 3, log2(N).
- DW1, 8, operand-1 width.
- DW2, 8, operand-2 width.
- BATCH, 4, samples per mini-batch (>=1).
- BATCH_BIT, 2, ceil(log2(BATCH)); with BATCH=1 use 1.
- ADD_LAT, 1, cycles from the enable edge until add_sum is valid (>=1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin a batch; honoured only in IDLE.
- in_valid  in  1  upstream dot-product vector valid.
- in_ready  out  1  block can accept a sample.
- add_en  out  1  enable to the adder stage.
- add_sum  in  DW1+DW2+N_BIT  adder output.
- acc_out  out  DW1+DW2+N_BIT+BATCH_BIT  batch result.
- out_valid  out  1  acc_out valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state except IDLE.
- sample_cnt  out  BATCH_BIT  samples accumulated in the current batch.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=0, add_en=0, out_valid=0, busy=0; acc_out=0, sample_cnt=0, latency counter=0.
- Reset asserted mid-batch aborts immediately. No partial result is emitted.
- Arithmetic: unsigned throughout. The accumulator is BATCH_BIT bits wider than add_sum, so no overflow is possible. add_sum is zero-extended before adding.
- State IDLE:
  - start=1 clears acc_out and sample_cnt, then moves to WAIT_IN.
  - out_ready is ignored.
- State WAIT_IN:
  - in_ready=1.
  - add_en is combinational: in_valid & in_ready. It is high only in the handshake cycle, so the adder captures the held vector on that edge.
  - A handshake moves to ADD and loads the latency counter with 1.
  - No handshake: stay; bubbles of any length are allowed.
- State ADD:
  - in_ready=0, add_en=0.
  - While latency counter < ADD_LAT: increment it.
  - When latency counter == ADD_LAT: acc_out <= acc_out + add_sum and sample_cnt <= sample_cnt+1.
  - Next state is DONE if sample_cnt == BATCH-1, otherwise WAIT_IN.
- Per-sample cost: 1 handshake cycle + ADD_LAT cycles. Minimum batch time is BATCH*(1+ADD_LAT) cycles from the first handshake to out_valid.
- State DONE:
  - out_valid=1. acc_out and out_valid stay stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE with out_valid=0.
  - acc_out keeps its value in IDLE until the next accepted start.
- start outside IDLE is ignored, including in the DONE handshake cycle.
- in_valid outside WAIT_IN is ignored; in_ready=0 there.
- sample_cnt reads 0 after the final sample of a batch (wrap at BATCH), and holds until the next start.

Optional Feature:
- Macro: MBGD_SEQ_MEAN_EN.
- Defined:
  - acc_out in DONE presents the batch mean: accumulated sum >> BATCH_BIT, zero-filled in the upper bits.
  - BATCH must equal 2**BATCH_BIT; the elaboration checks this and stops with an error otherwise.
- Undefined: acc_out presents the raw sum, and BATCH may be any value >= 1.

Test Plan:
- Basic batch:
  - Stimulus: defaults; ADD_LAT=1; adder model sums eight 16'd100 lanes; start, then 4 back-to-back samples.
  - Response: add_sum=800 per sample; out_valid 8 cycles after the first handshake; acc_out=3200 (mean build: 800).
- Backpressure and bubbles:
  - Stimulus: 2-cycle gaps in in_valid; out_ready low 5 cycles in DONE.
  - Response: in_ready low in ADD; add_en exactly 4 single-cycle pulses; acc_out=3200 held stable while out_valid=1 and out_ready=0.
- Maximum values:
  - Stimulus: all lanes 16'hFFFF.
  - Response: add_sum=524280; acc_out=2097120 with no overflow (mean: 524280).
- Ignored start:
  - Stimulus: start pulsed in WAIT_IN, ADD and DONE.
  - Response: no clear of acc_out or sample_cnt; a single result is produced.
- Reset mid-batch:
  - Stimulus: resetn low after 2 samples.
  - Response: all outputs 0 and state IDLE; a new start gives a clean 3200.
- ADD_LAT=3 variant:
  - Stimulus: same samples as the basic batch.
  - Response: accumulation 3 cycles after each handshake; out_valid 16 cycles after the first handshake.
